// File: rtl/nonce_reporter_pkg.sv
// Shared definitions for the nonce reporter: frame FSM encoding, result record
// and the frame checksum.
package nonce_reporter_pkg;

  localparam logic [7:0]  SYNC_DEFAULT = 8'h55;
  localparam int unsigned FRAME_LEN    = 7;
  localparam int unsigned RESULT_W     = 40;

  // Non-idle state values equal the 1-based byte position within the frame.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    JOB,
    N0,
    N1,
    N2,
    N3,
    CSUM = 3'(FRAME_LEN)
  } state_e;

  typedef struct packed {
    logic [7:0]  job;
    logic [31:0] nonce;
  } result_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] sync, input result_t r);
    return sync ^ r.job ^ r.nonce[7:0] ^ r.nonce[15:8] ^ r.nonce[23:16] ^ r.nonce[31:24];
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Result FIFO with wrap-bit pointers; push into a full FIFO succeeds only when
// a pop happens in the same cycle, and flush empties it on the next edge.
module nonce_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: defaults first so every path assigns the _d signals; no latches.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/nonce_reporter.sv
// Queues miner results and streams each one to the host as a 7-byte frame:
// SYNC, job, nonce LSB..MSB, XOR checksum.
module nonce_reporter
  import nonce_reporter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nonce_found,
  input  logic [31:0] nonce_in,
  input  logic [7:0]  job_id,
  input  logic        new_job,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);

  state_e     state_q, state_d;
  result_t    frame_q, head;
  logic       fifo_full, fifo_empty;
  logic       pop, push_req, drop;
  logic [7:0] drop_count_q;

  // A push coinciding with new_job belongs to the stale job: discarded, not a drop.
  assign push_req = nonce_found && !new_job;
  assign drop     = push_req && fifo_full && !pop;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESULT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .flush_i (new_job),
    .wdata_i ({job_id, nonce_in}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) frame_q <= head;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = HDR;
      HDR:     if (tx_ready) state_d = JOB;
      JOB:     if (tx_ready) state_d = N0;
      N0:      if (tx_ready) state_d = N1;
      N1:      if (tx_ready) state_d = N2;
      N2:      if (tx_ready) state_d = N3;
      N3:      if (tx_ready) state_d = CSUM;
      CSUM:    if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = (state_q == IDLE) && !fifo_empty;
    tx_valid = (state_q != IDLE);
    tx_data  = 8'h00;
    unique case (state_q)
      HDR:     tx_data = SYNC;
      JOB:     tx_data = frame_q.job;
      N0:      tx_data = frame_q.nonce[7:0];
      N1:      tx_data = frame_q.nonce[15:8];
      N2:      tx_data = frame_q.nonce[23:16];
      N3:      tx_data = frame_q.nonce[31:24];
      CSUM:    tx_data = frame_csum(SYNC, frame_q);
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count_q <= 8'h00;
    end else if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'h01;
    end
  end

  assign drop_count = drop_count_q;
  assign busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter (DEPTH=4, SYNC=8'h55): frame bytes, back-
// pressure, drops and saturation, flush on new_job, full-FIFO pop+push, reset.
module tb_nonce_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic        nonce_found;
  logic [31:0] nonce_in;
  logic [7:0]  job_id;
  logic        new_job;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [55:0] fa;
  logic [7:0]  lb;

  always #5 clk = ~clk;

  nonce_reporter #(.DEPTH(4), .SYNC(8'h55)) dut (
    .clk         (clk),
    .reset       (reset),
    .nonce_found (nonce_found),
    .nonce_in    (nonce_in),
    .job_id      (job_id),
    .new_job     (new_job),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] j, input logic [31:0] n);
    job_id      = j;
    nonce_in    = n;
    nonce_found = 1'b1;
    tick;
    nonce_found = 1'b0;
  endtask

  // Expected frame, byte k at bits [8k+7:8k].
  function automatic logic [55:0] frame_of(input logic [7:0] j, input logic [31:0] n);
    logic [7:0] cs;
    cs = 8'h55 ^ j ^ n[7:0] ^ n[15:8] ^ n[23:16] ^ n[31:24];
    return {cs, n[31:24], n[23:16], n[15:8], n[7:0], j, 8'h55};
  endfunction

  // Accept bytes first..last of frame f; every valid cycle must show the pending byte.
  task automatic recv_bytes(input string tag, input logic [55:0] f, input int first,
                            input int last, input bit toggle, output logic [7:0] last_b);
    last_b = 8'h00;
    for (int k = first; k <= last; k++) begin
      bit got_it;
      int budget;
      got_it = 1'b0;
      budget = 0;
      while (!got_it && budget < 100) begin
        tx_ready = toggle ? ~tx_ready : 1'b1;
        if (tx_valid) begin
          check($sformatf("%s_b%0d", tag, k), {32'h0, tx_data}, {32'h0, f[8*k +: 8]});
          if (tx_ready) begin
            got_it = 1'b1;
            last_b = tx_data;
          end
        end
        tick;
        budget++;
      end
      if (!got_it) check($sformatf("%s_timeout_b%0d", tag, k), 40'd0, 40'd1);
    end
    tx_ready = 1'b0;
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    bit saw;
    saw = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (tx_valid) saw = 1'b1;
      tick;
    end
    check(tag, {39'h0, saw}, 40'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    nonce_found = 1'b0;
    nonce_in    = 32'h0;
    job_id      = 8'h0;
    new_job     = 1'b0;
    tx_ready    = 1'b0;
    tick;
    tick;
    check("rst_tx_valid", {39'h0, tx_valid}, 40'h0);
    check("rst_tx_data", {32'h0, tx_data}, 40'h0);
    check("rst_drop", {32'h0, drop_count}, 40'h0);
    check("rst_busy", {39'h0, busy}, 40'h0);
    reset = 1'b1;
    tick;

    // Single result, host always ready.
    push(8'h03, 32'hDEADBEEF);
    recv_bytes("single", frame_of(8'h03, 32'hDEADBEEF), 0, 6, 1'b0, lb);
    check("single_csum", {32'h0, lb}, 40'h74);
    check("single_idle_valid", {39'h0, tx_valid}, 40'h0);
    check("single_idle_busy", {39'h0, busy}, 40'h0);

    // One frame stalled in HDR, then 6 back-to-back results: 4 queued, 2 dropped.
    push(8'h10, 32'h1000_0001);
    tick;
    check("stall_valid", {39'h0, tx_valid}, 40'h1);
    check("stall_hdr", {32'h0, tx_data}, 40'h55);
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i), 32'(32'h2000_0000 + i));
    check("burst_drop", {32'h0, drop_count}, 40'h2);
    check("burst_busy", {39'h0, busy}, 40'h1);
    check("burst_hdr_held", {32'h0, tx_data}, 40'h55);
    recv_bytes("burst_a", frame_of(8'h10, 32'h1000_0001), 0, 6, 1'b0, lb);
    for (int i = 0; i < 4; i++)
      recv_bytes($sformatf("burst_q%0d", i), frame_of(8'(8'h20 + i), 32'(32'h2000_0000 + i)),
                 0, 6, 1'b0, lb);
    idle_quiet("burst_no_extra", 10);
    check("burst_busy_end", {39'h0, busy}, 40'h0);

    // Host ready toggling every cycle.
    push(8'h5A, 32'h12345678);
    recv_bytes("toggle", frame_of(8'h5A, 32'h12345678), 0, 6, 1'b1, lb);
    check("toggle_csum", {32'h0, lb}, 40'h07);
    idle_quiet("toggle_idle", 4);

    // new_job while in N1 with two results queued; coincident result is discarded.
    fa = frame_of(8'h31, 32'hA1A1_0001);
    push(8'h31, 32'hA1A1_0001);
    push(8'h32, 32'hA1A1_0002);
    push(8'h33, 32'hA1A1_0003);
    recv_bytes("nj", fa, 0, 2, 1'b0, lb);
    check("nj_in_n1", {32'h0, tx_data}, {32'h0, fa[31:24]});
    new_job     = 1'b1;
    nonce_found = 1'b1;
    job_id      = 8'h3F;
    nonce_in    = 32'hBAD0_0000;
    tick;
    new_job     = 1'b0;
    nonce_found = 1'b0;
    check("nj_drop_kept", {32'h0, drop_count}, 40'h2);
    check("nj_n1_held", {32'h0, tx_data}, {32'h0, fa[31:24]});
    recv_bytes("nj", fa, 3, 6, 1'b0, lb);
    check("nj_busy_after_csum", {39'h0, busy}, 40'h0);
    idle_quiet("nj_no_more", 12);

    // Full FIFO: pop and push on the same edge must not drop.
    push(8'h41, 32'h4000_0000);
    tick;
    for (int i = 1; i <= 4; i++) push(8'(8'h41 + i), 32'(32'h4000_0000 + i));
    check("full_pre_drop", {32'h0, drop_count}, 40'h2);
    recv_bytes("full_a", frame_of(8'h41, 32'h4000_0000), 0, 6, 1'b0, lb);
    check("full_gap_idle", {39'h0, tx_valid}, 40'h0);
    push(8'h46, 32'h4000_0005);
    check("full_poppush_nodrop", {32'h0, drop_count}, 40'h2);
    push(8'h47, 32'h4000_0006);
    check("full_still_depth", {32'h0, drop_count}, 40'h3);
    for (int i = 1; i <= 5; i++)
      recv_bytes($sformatf("full_q%0d", i), frame_of(8'(8'h41 + i), 32'(32'h4000_0000 + i)),
                 0, 6, 1'b0, lb);
    idle_quiet("full_no_extra", 10);

    // Saturating drop counter.
    job_id      = 8'hA0;
    nonce_in    = 32'hCAFEF00D;
    nonce_found = 1'b1;
    repeat (300) tick;
    check("sat_drop", {32'h0, drop_count}, 40'hFF);
    tick;
    check("sat_drop_hold", {32'h0, drop_count}, 40'hFF);
    nonce_found = 1'b0;

    // Reset while in N2 aborts the frame, flushes the FIFO, ignores nonce_found.
    fa = frame_of(8'hA0, 32'hCAFEF00D);
    recv_bytes("rst", fa, 0, 3, 1'b0, lb);
    check("rst_in_n2", {32'h0, tx_data}, {32'h0, fa[39:32]});
    reset       = 1'b0;
    nonce_found = 1'b1;
    tick;
    check("midrst_tx_valid", {39'h0, tx_valid}, 40'h0);
    check("midrst_tx_data", {32'h0, tx_data}, 40'h0);
    check("midrst_busy", {39'h0, busy}, 40'h0);
    check("midrst_drop", {32'h0, drop_count}, 40'h0);
    reset       = 1'b1;
    nonce_found = 1'b0;
    tx_ready    = 1'b1;
    idle_quiet("rst_no_partial", 12);
    check("rst_busy_after", {39'h0, busy}, 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
